apb_rmw_master: RTL and testbench
=================================

Name: apb_rmw_master

Overview:
- Parametrised APB master that turns single-beat commands into APB transfers: READ, WRITE, and atomic read-modify-write ADD.
- Sits between a local command/response interface and one APB slave port.
- Successor of the fixed-address increment master. Generalises address, data width and increment operand, and adds command/response handshakes and PSLVERR reporting.

Parameters:
- ADDR_W, 32, width of paddr_o and cmd_addr_i
- DATA_W, 32, width of pwdata_o, prdata_i, cmd_data_i, rsp_data_o
- TIMEOUT_CYCLES, 16, maximum ACCESS wait cycles before abort; used only with APB_TIMEOUT_EN; must be >= 1

Ports:
- pclk  in  1  clock
- preset_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_op_i  in  2  00 NOP, 01 READ, 10 WRITE, 11 RMW_ADD
- cmd_addr_i  in  ADDR_W  target address
- cmd_data_i  in  DATA_W  write data (WRITE) or addend (RMW_ADD)
- rsp_valid_o  out  1  response valid, held until rsp_ready_i
- rsp_ready_i  in  1  response consumer ready
- rsp_data_o  out  DATA_W  read data (READ), written data (WRITE, RMW_ADD)
- rsp_err_o  out  1  transfer error (PSLVERR or timeout)
- psel_o  out  1  APB PSEL
- penable_o  out  1  APB PENABLE
- paddr_o  out  ADDR_W  APB PADDR
- pwrite_o  out  1  APB PWRITE
- pwdata_o  out  DATA_W  APB PWDATA
- prdata_i  in  DATA_W  APB PRDATA
- pready_i  in  1  APB PREADY
- pslverr_i  in  1  APB PSLVERR

Behaviour:
- Clock pclk; reset preset_n asynchronous, active-low. All registers clear on reset assertion regardless of in-flight transfer.
- Reset values: state IDLE; psel_o, penable_o, pwrite_o, rsp_valid_o, rsp_err_o = 0; paddr_o, pwdata_o, rsp_data_o = 0; cmd_ready_o = 1.
- Mid-transfer reset: the APB transfer is dropped and no response is produced.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o = 1; no other state asserts cmd_ready_o.
  - On cmd_valid_i with op != NOP: latch op, addr and data, then go to SETUP.
  - NOP: consumed in one cycle; no APB traffic, no response.
- SETUP: psel_o=1, penable_o=0; always moves to ACCESS next cycle.
- ACCESS: psel_o=1, penable_o=1; stays in ACCESS while pready_i=0.
- On pready_i=1 in ACCESS:
  - READ: capture prdata_i into rsp_data_o, rsp_err_o=pslverr_i; go to RESP.
  - WRITE: rsp_data_o = latched data, rsp_err_o=pslverr_i; go to RESP.
  - RMW_ADD, read phase, pslverr_i=0: sum_q = prdata_i + addend, truncated mod 2^DATA_W (carry discarded); set wr_phase, go directly to SETUP (no IDLE gap).
  - RMW_ADD, read phase, pslverr_i=1: skip write; rsp_data_o=prdata_i, rsp_err_o=1; go to RESP.
  - RMW_ADD, write phase: rsp_data_o=sum_q, rsp_err_o=pslverr_i; go to RESP.
- pwrite_o = 1 for WRITE and the RMW write phase, else 0. It is registered, stable through SETUP and ACCESS, and 0 outside psel_o.
- paddr_o = latched address while psel_o, else 0. pwdata_o = write data while psel_o and pwrite_o, else 0.
- RESP: rsp_valid_o=1; rsp_data_o and rsp_err_o stable; go to IDLE on rsp_ready_i. A new command can be accepted the cycle after.
- Latency, zero wait states: accept cycle N; SETUP N+1; ACCESS N+2; rsp_valid_o at N+3. RMW_ADD: rsp_valid_o at N+5.
- prdata_i and pslverr_i are sampled only when psel&penable&pready.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: a counter increments each ACCESS cycle with pready_i=0 and clears on SETUP. On reaching TIMEOUT_CYCLES: deassert psel_o and penable_o, rsp_err_o=1, rsp_data_o=0, go to RESP. If an RMW read times out, no write phase is issued.
- Not defined: no counter; ACCESS waits indefinitely for pready_i.

Decomposition:
- Package apb_master_pkg: apb_op_t enum (NOP, READ, WRITE, RMW_ADD), apb_mstate_t enum (IDLE, SETUP, ACCESS, RESP), op encoding constants.
- Sub-module apb_timeout_cnt: clear, count-enable, expire output; parametrised by TIMEOUT_CYCLES; instantiated only under APB_TIMEOUT_EN.

Test Plan:
- READ addr 0xA000, slave returns 0x1234, zero waits -> SETUP/ACCESS one cycle each; rsp_data_o=0x1234, rsp_err_o=0, rsp_valid_o 3 cycles after accept.
- RMW_ADD addr 0xA000, addend 1, slave holds 0xFFFFFFFF -> read then back-to-back write of pwdata_o=0x00000000 (wrap); rsp_data_o=0, rsp_err_o=0.
- WRITE 0xDEAD_BEEF to 0x10 with pready_i low for 3 ACCESS cycles -> psel/penable/paddr/pwdata held stable 4 ACCESS cycles; rsp_err_o=0.
- RMW_ADD, pslverr_i=1 on read -> no write phase; rsp_err_o=1, rsp_data_o=read data.
- rsp_ready_i held low 5 cycles, second command valid -> cmd_ready_o=0 until response consumed; preset_n low during ACCESS -> all outputs return to reset values immediately.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, pready_i never high -> abort after 4 wait cycles; rsp_err_o=1, rsp_data_o=0.

Source files
------------

// File: rtl/apb_rmw_master_pkg.sv
// Shared types for the APB read/modify/write master: command opcodes and FSM states.
package apb_master_pkg;

    localparam logic [1:0] OP_ENC_NOP     = 2'b00;
    localparam logic [1:0] OP_ENC_READ    = 2'b01;
    localparam logic [1:0] OP_ENC_WRITE   = 2'b10;
    localparam logic [1:0] OP_ENC_RMW_ADD = 2'b11;

    typedef enum logic [1:0] {
        NOP     = OP_ENC_NOP,
        READ    = OP_ENC_READ,
        WRITE   = OP_ENC_WRITE,
        RMW_ADD = OP_ENC_RMW_ADD
    } apb_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETUP  = 2'b01,
        ACCESS = 2'b10,
        RESP   = 2'b11
    } apb_mstate_t;

endpackage

// File: rtl/apb_rmw_master_if.sv
// Command, response and APB bus signals of the RMW master, with master (DUT) and slave views.
interface apb_rmw_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Command and response both transfer on a cycle where valid && ready are high;
    // once raised, valid and its payload hold until that cycle.
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic [DATA_W-1:0] cmd_data_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_data_o;
    logic              rsp_err_o;
    logic              psel_o;
    logic              penable_o;
    logic [ADDR_W-1:0] paddr_o;
    logic              pwrite_o;
    logic [DATA_W-1:0] pwdata_o;
    logic [DATA_W-1:0] prdata_i;
    logic              pready_i;
    logic              pslverr_i;

    modport master (
        input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
        input  prdata_i, pready_i, pslverr_i,
        output cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, rsp_ready_i,
        output prdata_i, pready_i, pslverr_i,
        input  cmd_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
    );

endinterface

// File: rtl/apb_rmw_master_timeout_cnt.sv
// ACCESS-phase wait counter; expire pulses on the wait cycle that brings the count to TIMEOUT_CYCLES.
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (count_en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire = count_en && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_rmw_master.sv
// APB master executing READ, WRITE and atomic RMW_ADD commands.
// Optional ACCESS watchdog compiled in with `define APB_TIMEOUT_EN.
module apb_rmw_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        preset_n,
    apb_rmw_if.master   bus,
    output apb_mstate_t dbg_state
);

    apb_mstate_t       state_q, state_d;
    apb_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] sum_q;
    logic              wr_phase_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;
    logic              accept;
    logic              timeout_hit;

    assign accept    = (state_q == IDLE) && bus.cmd_valid_i &&
                       (apb_op_t'(bus.cmd_op_i) != NOP);
    assign dbg_state = state_q;

`ifdef APB_TIMEOUT_EN
    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (pclk),
        .rst_n    (preset_n),
        .clear    (state_q == SETUP),
        .count_en ((state_q == ACCESS) && !bus.pready_i),
        .expire   (timeout_hit)
    );
`else
    // Without the watchdog ACCESS waits for pready_i indefinitely.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (accept) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (bus.pready_i) begin
                    // A clean RMW read chains straight into its write SETUP.
                    if (op_q == RMW_ADD && !wr_phase_q && !bus.pslverr_i) state_d = SETUP;
                    else                                                   state_d = RESP;
                end else if (timeout_hit) begin
                    state_d = RESP;
                end
            end
            RESP:   if (bus.rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            op_q       <= NOP;
            addr_q     <= '0;
            data_q     <= '0;
            sum_q      <= '0;
            wr_phase_q <= 1'b0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            op_q       <= apb_op_t'(bus.cmd_op_i);
            addr_q     <= bus.cmd_addr_i;
            data_q     <= bus.cmd_data_i;
            wr_phase_q <= 1'b0;
        end else if (state_q == ACCESS && bus.pready_i) begin
            case (op_q)
                READ: begin
                    rsp_data_q <= bus.prdata_i;
                    rsp_err_q  <= bus.pslverr_i;
                end
                WRITE: begin
                    rsp_data_q <= data_q;
                    rsp_err_q  <= bus.pslverr_i;
                end
                RMW_ADD: begin
                    if (wr_phase_q) begin
                        rsp_data_q <= sum_q;
                        rsp_err_q  <= bus.pslverr_i;
                    end else if (bus.pslverr_i) begin
                        rsp_data_q <= bus.prdata_i;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        sum_q      <= bus.prdata_i + data_q;
                        wr_phase_q <= 1'b1;
                    end
                end
                default: begin
                    rsp_err_q <= rsp_err_q;
                end
            endcase
        end else if (state_q == ACCESS && timeout_hit) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
        end
    end

    // Bus outputs are pure decodes of registered state, so they clear with reset.
    always_comb begin
        bus.cmd_ready_o = (state_q == IDLE);
        bus.psel_o      = (state_q == SETUP) || (state_q == ACCESS);
        bus.penable_o   = (state_q == ACCESS);
        bus.pwrite_o    = bus.psel_o && ((op_q == WRITE) || wr_phase_q);
        bus.paddr_o     = '0;
        bus.pwdata_o    = '0;
        if (bus.psel_o) bus.paddr_o = addr_q;
        if (bus.pwrite_o) bus.pwdata_o = wr_phase_q ? sum_q : data_q;
        bus.rsp_valid_o = (state_q == RESP);
        bus.rsp_data_o  = rsp_data_q;
        bus.rsp_err_o   = rsp_err_q;
    end

endmodule

// File: tb/tb_apb_rmw_master.sv
// Directed bench for apb_rmw_master: bus timing, RMW wrap, wait states, errors, backpressure, reset.
module tb_apb_rmw_master;
    import apb_master_pkg::*;

    logic        pclk;
    logic        preset_n;
    apb_mstate_t dbg_state;
    int          n_pass;
    int          n_total;
    int          lat;

    apb_rmw_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_rmw_master #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .bus       (bus.master),
        .dbg_state (dbg_state)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // Presents one command, lets it be accepted, and returns in the SETUP cycle.
    task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_op_i    = op;
        bus.cmd_addr_i  = addr;
        bus.cmd_data_i  = data;
        @(negedge pclk);
        bus.cmd_valid_i = 1'b0;
    endtask

    // Cycles since accept until rsp_valid_o, bounded by max.
    task automatic wait_rsp(input int max, output int n);
        n = 1;
        while (!bus.rsp_valid_o && n < max) begin
            @(negedge pclk);
            n++;
        end
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        preset_n        = 1'b0;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_op_i    = 2'b00;
        bus.cmd_addr_i  = '0;
        bus.cmd_data_i  = '0;
        bus.rsp_ready_i = 1'b0;
        bus.prdata_i    = '0;
        bus.pready_i    = 1'b0;
        bus.pslverr_i   = 1'b0;
        repeat (2) @(negedge pclk);
        chk("rst_cmd_ready", bus.cmd_ready_o, 1'b1);
        chk("rst_bus", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.rsp_valid_o, bus.rsp_err_o}, 5'b0);
        chk("rst_paddr", bus.paddr_o, 32'h0);
        chk("rst_state", dbg_state, IDLE);
        preset_n = 1'b1;
        @(negedge pclk);

        // READ 0xA000 -> 0x1234, zero wait states
        bus.pready_i = 1'b1; bus.prdata_i = 32'h1234; bus.rsp_ready_i = 1'b1;
        send_cmd(OP_ENC_READ, 32'hA000, 32'h0);
        chk("rd_setup_ctl", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.cmd_ready_o}, 4'b1000);
        chk("rd_setup_addr", bus.paddr_o, 32'hA000);
        @(negedge pclk);
        chk("rd_access_ctl", {bus.psel_o, bus.penable_o, bus.rsp_valid_o}, 3'b110);
        @(negedge pclk);
        chk("rd_rsp_ctl", {bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o}, 3'b100);
        chk("rd_rsp_data", bus.rsp_data_o, 32'h1234);
        @(negedge pclk);
        chk("rd_idle", {bus.rsp_valid_o, bus.cmd_ready_o}, 2'b01);

        // RMW_ADD 0xA000 +1 on 0xFFFFFFFF wraps to 0
        bus.prdata_i = 32'hFFFF_FFFF;
        send_cmd(OP_ENC_RMW_ADD, 32'hA000, 32'h1);
        chk("rmw1_rd_setup", {bus.psel_o, bus.penable_o, bus.pwrite_o}, 3'b100);
        @(negedge pclk);
        chk("rmw1_rd_access", {bus.psel_o, bus.penable_o, bus.pwrite_o}, 3'b110);
        @(negedge pclk);
        chk("rmw1_wr_setup", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.rsp_valid_o}, 4'b1010);
        chk("rmw1_wr_pwdata", bus.pwdata_o, 32'h0);
        chk("rmw1_wr_paddr", bus.paddr_o, 32'hA000);
        @(negedge pclk);
        chk("rmw1_wr_access", {bus.psel_o, bus.penable_o, bus.pwrite_o}, 3'b111);
        @(negedge pclk);
        chk("rmw1_rsp_ctl", {bus.rsp_valid_o, bus.rsp_err_o}, 2'b10);
        chk("rmw1_rsp_data", bus.rsp_data_o, 32'h0);
        @(negedge pclk);

        // RMW_ADD 0x10: 0xFFFFFFF0 + 0x25 = 0x15 (carry dropped)
        bus.prdata_i = 32'hFFFF_FFF0;
        send_cmd(OP_ENC_RMW_ADD, 32'h10, 32'h25);
        repeat (2) @(negedge pclk);
        chk("rmw2_wr_pwdata", bus.pwdata_o, 32'h15);
        repeat (2) @(negedge pclk);
        chk("rmw2_rsp_data", {bus.rsp_valid_o, bus.rsp_data_o}, {1'b1, 32'h15});
        @(negedge pclk);

        // WRITE 0xDEADBEEF to 0x10 with 3 wait states
        bus.pready_i = 1'b0;
        send_cmd(OP_ENC_WRITE, 32'h10, 32'hDEAD_BEEF);
        chk("wr_setup_ctl", {bus.psel_o, bus.penable_o, bus.pwrite_o}, 3'b101);
        chk("wr_setup_pwdata", bus.pwdata_o, 32'hDEAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            chk($sformatf("wr_hold%0d_ctl", i), {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.rsp_valid_o}, 4'b1110);
            chk($sformatf("wr_hold%0d_paddr", i), bus.paddr_o, 32'h10);
            chk($sformatf("wr_hold%0d_pwdata", i), bus.pwdata_o, 32'hDEAD_BEEF);
        end
        bus.pready_i = 1'b1;
        @(negedge pclk);
        chk("wr_rsp_ctl", {bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o}, 3'b100);
        chk("wr_rsp_data", bus.rsp_data_o, 32'hDEAD_BEEF);
        @(negedge pclk);

        // RMW_ADD with PSLVERR on the read: no write phase
        bus.pslverr_i = 1'b1; bus.prdata_i = 32'h55AA;
        send_cmd(OP_ENC_RMW_ADD, 32'h40, 32'h3);
        wait_rsp(10, lat);
        chk("rmw_err_latency", lat, 3);
        chk("rmw_err_ctl", {bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o}, 3'b110);
        chk("rmw_err_data", bus.rsp_data_o, 32'h55AA);
        bus.pslverr_i = 1'b0;
        @(negedge pclk);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: abort after 4 wait cycles
        bus.pready_i = 1'b0;
        send_cmd(OP_ENC_READ, 32'h80, 32'h0);
        wait_rsp(20, lat);
        chk("to_latency", lat, 6);
        chk("to_ctl", {bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o, bus.penable_o}, 4'b1100);
        chk("to_data", bus.rsp_data_o, 32'h0);
        bus.pready_i = 1'b1;
        @(negedge pclk);
`endif

        // Response backpressure with a second command waiting
        bus.rsp_ready_i = 1'b0; bus.prdata_i = 32'h77; bus.pready_i = 1'b1;
        send_cmd(OP_ENC_READ, 32'h30, 32'h0);
        bus.cmd_valid_i = 1'b1; bus.cmd_op_i = OP_ENC_WRITE;
        bus.cmd_addr_i = 32'h20; bus.cmd_data_i = 32'hCAFE;
        wait_rsp(10, lat);
        chk("bp_latency", lat, 3);
        for (int i = 0; i < 5; i++) begin
            @(negedge pclk);
            chk($sformatf("bp_hold%0d_ctl", i), {bus.rsp_valid_o, bus.cmd_ready_o, bus.psel_o}, 3'b100);
            chk($sformatf("bp_hold%0d_data", i), bus.rsp_data_o, 32'h77);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge pclk);
        chk("bp_release", {bus.rsp_valid_o, bus.cmd_ready_o}, 2'b01);
        bus.rsp_ready_i = 1'b0;
        bus.pready_i = 1'b0;
        @(negedge pclk);
        bus.cmd_valid_i = 1'b0;
        chk("bp2_setup_ctl", {bus.psel_o, bus.penable_o, bus.pwrite_o}, 3'b101);
        chk("bp2_setup_paddr", bus.paddr_o, 32'h20);
        chk("bp2_setup_pwdata", bus.pwdata_o, 32'hCAFE);
        @(negedge pclk);
        chk("bp2_access", {bus.psel_o, bus.penable_o}, 2'b11);

        // Reset asserted mid-ACCESS
        #2 preset_n = 1'b0;
        #1;
        chk("mrst_ctl", {bus.psel_o, bus.penable_o, bus.pwrite_o, bus.rsp_valid_o, bus.rsp_err_o, bus.cmd_ready_o}, 6'b000001);
        chk("mrst_paddr", bus.paddr_o, 32'h0);
        chk("mrst_pwdata", bus.pwdata_o, 32'h0);
        chk("mrst_rsp_data", bus.rsp_data_o, 32'h0);
        chk("mrst_state", dbg_state, IDLE);
        @(negedge pclk);
        preset_n = 1'b1; bus.pready_i = 1'b1; bus.rsp_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            chk($sformatf("mrst_quiet%0d", i), {bus.rsp_valid_o, bus.psel_o}, 2'b00);
        end

        // NOP: consumed, no traffic, no response
        send_cmd(OP_ENC_NOP, 32'h44, 32'h9);
        chk("nop_ctl", {bus.psel_o, bus.cmd_ready_o, bus.rsp_valid_o}, 3'b010);
        chk("nop_state", dbg_state, IDLE);
        @(negedge pclk);
        chk("nop_quiet", {bus.psel_o, bus.rsp_valid_o}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
